store_unit: RTL and testbench

- Memory-stage store path of the MIPS pipeline.
- Turns SB/SH/SW into byte-lane-aligned write data and byte strobes, and flags misaligned store addresses.
- Drives a single-outstanding SRAM-like data bus handshake (req/addr_ok/data_ok) and stalls the pipeline until the write completes.
- Write-side counterpart of the load-extraction logic in the writeback stage.

---
 rtl/store_unit.sv | 184 ++++++++++++++++++
 tb/tb_store_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_unit
// Description : Memory-stage store path. Converts SB/SH/SW into lane-aligned
//               write data and byte strobes, flags misaligned stores, and runs
//               a single-outstanding req/addr_ok/data_ok write handshake while
//               stalling the pipeline until the write completes.
//               Optional feature macro: STORE_TIMEOUT_EN (WAIT-state watchdog).
// Revision    : 1.0 - initial release
// ============================================================================
module store_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        memwriteM,
    input  logic        flushM,
    input  logic [5:0]  alucontrolM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic        saddrerrM,
    output logic        stallM,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    output logic        bus_timeout
);

    // Store opcodes as carried on alucontrolM.
    localparam logic [5:0] c_sb_control = 6'h28;
    localparam logic [5:0] c_sh_control = 6'h29;
    localparam logic [5:0] c_sw_control = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic        w_is_sb;
    logic        w_is_sh;
    logic        w_is_sw;
    logic        w_known_op;
    logic        w_misaligned;
    logic        w_start;
    logic        w_wait_done;
    logic [31:0] w_lane_wdata;
    logic [3:0]  w_lane_wstrb;
    logic [1:0]  w_lane_size;

    // A terminal count that does not fit in CNT_W bits can never be reached;
    // this block exists only for such an invalid pairing and holds no logic.
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (1 << CNT_W))) begin : g_cfg_invalid
    end

    assign w_is_sb    = (alucontrolM == c_sb_control);
    assign w_is_sh    = (alucontrolM == c_sh_control);
    assign w_is_sw    = (alucontrolM == c_sw_control);
    assign w_known_op = w_is_sb | w_is_sh | w_is_sw;

    // Halfwords need bit 0 clear, words need both low bits clear.
    assign w_misaligned = (w_is_sh & aluoutM[0]) | (w_is_sw & (aluoutM[1:0] != 2'b00));
    assign saddrerrM    = memwriteM & w_misaligned;

    // Unknown opcodes never start a transaction.
    assign w_start     = memwriteM & w_known_op & ~saddrerrM & ~flushM & (r_state == ST_IDLE);
    assign w_wait_done = (r_state == ST_WAIT) & data_data_ok;

    // Stall from acceptance until the completing data_ok cycle.
    assign stallM = w_start | ((r_state != ST_IDLE) & ~w_wait_done);

    // Replicate store data across the lanes and select the byte enables.
    always_comb begin
        w_lane_wdata = 32'h0000_0000;
        w_lane_wstrb = 4'b0000;
        w_lane_size  = 2'd0;
        if (w_is_sb) begin
            w_lane_wdata = {4{writedataM[7:0]}};
            w_lane_wstrb = 4'b0001 << aluoutM[1:0];
            w_lane_size  = 2'd0;
        end else if (w_is_sh) begin
            w_lane_wdata = {2{writedataM[15:0]}};
            w_lane_wstrb = aluoutM[1] ? 4'b1100 : 4'b0011;
            w_lane_size  = 2'd1;
        end else if (w_is_sw) begin
            w_lane_wdata = writedataM;
            w_lane_wstrb = 4'b1111;
            w_lane_size  = 2'd2;
        end
    end

`ifdef STORE_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    assign bus_timeout = r_timeout;
`else
    assign bus_timeout = 1'b0;
`endif

    // Handshake FSM with registered bus fields; data_req is decoded from state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
            r_wstrb <= 4'b0000;
`ifdef STORE_TIMEOUT_EN
            r_cnt     <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef STORE_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr  <= aluoutM;
                        r_size  <= w_lane_size;
                        r_wdata <= w_lane_wdata;
                        r_wstrb <= w_lane_wstrb;
                        r_wr    <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // The request is held until accepted; a flush cannot cancel it.
                    if (data_addr_ok) begin
                        if (data_data_ok) begin
                            r_wr    <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT;
`ifdef STORE_TIMEOUT_EN
                            r_cnt   <= '0;
`endif
                        end
                    end
                end
                ST_WAIT: begin
                    if (data_data_ok) begin
                        r_wr    <= 1'b0;
                        r_state <= ST_IDLE;
`ifdef STORE_TIMEOUT_EN
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_timeout <= 1'b1;
                        r_wr      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_req   = (r_state == ST_REQ);
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wdata = r_wdata;
    assign data_wstrb = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_unit
// Description : Self-checking bench for store_unit: vector table, directed
//               multi-cycle sequences and randomized cycles against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_unit;

    localparam logic [5:0] OP_SB = 6'h28;
    localparam logic [5:0] OP_SH = 6'h29;
    localparam logic [5:0] OP_SW = 6'h2B;

    logic        clk = 1'b0;
    logic        resetn;
    logic        memwriteM;
    logic        flushM;
    logic [5:0]  alucontrolM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        saddrerrM;
    logic        stallM;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        bus_timeout;

    always #5 clk = ~clk;

    store_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .memwriteM    (memwriteM),
        .flushM       (flushM),
        .alucontrolM  (alucontrolM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .saddrerrM    (saddrerrM),
        .stallM       (stallM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .bus_timeout  (bus_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phase 0 = no store in flight, 1 = request open on the
    // bus, 2 = address accepted and completion outstanding.
    int          phase = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic [1:0]  m_size = '0;
    logic        m_fresh_reset = 1'b1;

    logic        obs_stall, obs_req, obs_err, obs_wr;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_wstrb;
    logic [1:0]  obs_size;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [1:0]  exp_size;
        logic        exp_err;
        logic        exp_go;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int op_bytes(input logic [5:0] op);
        if (op == OP_SB) return 1;
        if (op == OP_SH) return 2;
        if (op == OP_SW) return 4;
        return 0;
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, advance the model.
    task automatic step(input logic rn, input logic mw, input logic fl, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic aok, input logic dok);
        int   nb;
        logic exp_err, acc, exp_stall;
        resetn = rn; memwriteM = mw; flushM = fl; alucontrolM = op;
        aluoutM = a; writedataM = wd; data_addr_ok = aok; data_data_ok = dok;
        @(negedge clk);
        nb        = op_bytes(op);
        exp_err   = mw && ((nb == 2 && (a % 2) != 0) || (nb == 4 && (a % 4) != 0));
        acc       = mw && (nb != 0) && !exp_err && !fl && (phase == 0);
        exp_stall = acc || (phase == 1) || (phase == 2 && !dok);
        obs_stall = stallM; obs_req = data_req; obs_err = saddrerrM; obs_wr = data_wr;
        obs_addr = data_addr; obs_wdata = data_wdata; obs_wstrb = data_wstrb; obs_size = data_size;
        chk("saddrerrM", saddrerrM, exp_err);
        chk("stallM", stallM, exp_stall);
        chk("data_req", data_req, phase == 1);
        chk("bus_timeout", bus_timeout, 1'b0);
        chk("data_addr", data_addr, m_addr);
        chk("data_wdata", data_wdata, m_wdata);
        chk("data_wstrb", data_wstrb, m_wstrb);
        chk("data_size", data_size, m_size);
        if (phase == 1 || m_fresh_reset) chk("data_wr", data_wr, phase == 1);
        m_fresh_reset = 1'b0;
        if (!rn) begin
            phase = 0; m_addr = '0; m_wdata = '0; m_wstrb = '0; m_size = '0;
            m_fresh_reset = 1'b1;
        end else if (acc) begin
            m_addr  = a;
            m_wdata = (nb == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
                      (nb == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
            m_wstrb = 4'(((1 << nb) - 1) << (a % 4));
            m_size  = 2'($clog2(nb));
            phase   = 1;
        end else if (phase == 1 && aok) begin
            phase = dok ? 0 : 2;
        end else if (phase == 2 && dok) begin
            phase = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic aok, input logic dok);
        step(1'b1, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, aok, dok);
    endtask

    initial begin
        int stall_cnt;
        tbl[0] = '{OP_SB, 32'h1003, 32'h0000_00A5, 32'hA5A5_A5A5, 4'b1000, 2'd0, 1'b0, 1'b1};
        tbl[1] = '{OP_SB, 32'h1000, 32'h1234_5678, 32'h7878_7878, 4'b0001, 2'd0, 1'b0, 1'b1};
        tbl[2] = '{OP_SB, 32'h1001, 32'hFFFF_FF3C, 32'h3C3C_3C3C, 4'b0010, 2'd0, 1'b0, 1'b1};
        tbl[3] = '{OP_SH, 32'h2002, 32'h1234_BEEF, 32'hBEEF_BEEF, 4'b1100, 2'd1, 1'b0, 1'b1};
        tbl[4] = '{OP_SH, 32'h2000, 32'hCAFE_0102, 32'h0102_0102, 4'b0011, 2'd1, 1'b0, 1'b1};
        tbl[5] = '{OP_SH, 32'h2001, 32'h1234_BEEF, 32'h0,         4'b0000, 2'd0, 1'b1, 1'b0};
        tbl[6] = '{OP_SW, 32'h3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111, 2'd2, 1'b0, 1'b1};
        tbl[7] = '{OP_SW, 32'h3002, 32'hDEAD_BEEF, 32'h0,         4'b0000, 2'd0, 1'b1, 1'b0};
        tbl[8] = '{OP_SW, 32'h3001, 32'hDEAD_BEEF, 32'h0,         4'b0000, 2'd0, 1'b1, 1'b0};
        tbl[9] = '{6'h00, 32'h4000, 32'h5555_AAAA, 32'h0,         4'b0000, 2'd0, 1'b0, 1'b0};

        resetn = 1'b0; memwriteM = 1'b0; flushM = 1'b0; alucontrolM = 6'h00;
        aluoutM = '0; writedataM = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Vector table: accept cycle, REQ with immediate addr_ok, then data_ok.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, tbl[i].op, tbl[i].a, tbl[i].wd, 1'b0, 1'b0);
            chk("tbl_err", obs_err, tbl[i].exp_err);
            chk("tbl_accept_stall", obs_stall, tbl[i].exp_go);
            idle(1'b1, 1'b0);
            chk("tbl_req", obs_req, tbl[i].exp_go);
            if (tbl[i].exp_go) begin
                chk("tbl_addr", obs_addr, tbl[i].a);
                chk("tbl_wdata", obs_wdata, tbl[i].exp_wdata);
                chk("tbl_wstrb", obs_wstrb, tbl[i].exp_wstrb);
                chk("tbl_size", obs_size, tbl[i].exp_size);
            end
            idle(1'b0, 1'b1);
        end

        // SB with data_ok two cycles into WAIT: stall high for four cycles.
        stall_cnt = 0;
        step(1'b1, 1'b1, 1'b0, OP_SB, 32'h1003, 32'h0000_00A5, 1'b0, 1'b0);
        stall_cnt += int'(obs_stall);
        idle(1'b1, 1'b0); stall_cnt += int'(obs_stall);
        chk("seqA_wstrb", obs_wstrb, 4'b1000);
        chk("seqA_wdata", obs_wdata, 32'hA5A5_A5A5);
        idle(1'b0, 1'b0); stall_cnt += int'(obs_stall);
        idle(1'b0, 1'b0); stall_cnt += int'(obs_stall);
        idle(1'b0, 1'b1); stall_cnt += int'(obs_stall);
        chk("seqA_release", obs_stall, 1'b0);
        idle(1'b0, 1'b0); stall_cnt += int'(obs_stall);
        chk("seqA_stall_cycles", stall_cnt, 4);

        // SW with addr_ok withheld five cycles and a flush pulse mid-REQ.
        step(1'b1, 1'b1, 1'b0, OP_SW, 32'h3000, 32'h89AB_CDEF, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, (k == 2), 6'h00, 32'h0, 32'h0, 1'b0, 1'b0);
            chk("seqB_req_held", obs_req, 1'b1);
            chk("seqB_addr", obs_addr, 32'h3000);
            chk("seqB_wdata", obs_wdata, 32'h89AB_CDEF);
        end
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);

        // addr_ok and data_ok together, then a store in the very next cycle.
        step(1'b1, 1'b1, 1'b0, OP_SH, 32'h2000, 32'h0000_1111, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, OP_SB, 32'h1002, 32'h0000_0077, 1'b0, 1'b0);
        chk("seqC_accept", obs_stall, 1'b1);
        idle(1'b1, 1'b1);
        chk("seqC_req", obs_req, 1'b1);
        chk("seqC_wstrb", obs_wstrb, 4'b0100);
        idle(1'b0, 1'b0);
        chk("seqC_done", obs_stall, 1'b0);

        // Reset while in WAIT.
        step(1'b1, 1'b1, 1'b0, OP_SW, 32'h3004, 32'h0BAD_F00D, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 6'h00, 32'h0, 32'h0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("seqD_req", obs_req, 1'b0);
        chk("seqD_stall", obs_stall, 1'b0);
        chk("seqD_wr", obs_wr, 1'b0);
        chk("seqD_addr", obs_addr, 32'h0);
        chk("seqD_wdata", obs_wdata, 32'h0);
        chk("seqD_wstrb", obs_wstrb, 4'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 3))
                0:       op = OP_SB;
                1:       op = OP_SH;
                2:       op = OP_SW;
                default: op = 6'($urandom);
            endcase
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0), op, $urandom, $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
